// File: rtl/ft_async_pkg.sv
// rtl/ft_async_pkg.sv - shared encodings and widths for the FT245 async responder
package ft_async_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_WAIT    = 2'd1,
    RX_DRIVE   = 2'd2,
    RX_RECOVER = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_ACTIVE  = 2'd1,
    TX_RECOVER = 2'd2
  } tx_state_t;

endpackage

// File: rtl/ft_sync_fifo.sv
// rtl/ft_sync_fifo.sv - show-ahead synchronous byte FIFO with full/empty flags
module ft_sync_fifo #(
  parameter int DATA = 8,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [DATA-1:0] wdata,
  input  logic            pop,
  output logic [DATA-1:0] rdata,
  output logic            full,
  output logic            empty
);

  localparam int              DEPTH   = 1 << ADDR;
  localparam logic [ADDR:0]   DEPTH_C = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   CNT_ONE = 1;
  localparam logic [ADDR-1:0] PTR_ONE = 1;

  logic [DATA-1:0] mem [DEPTH];
  logic [ADDR-1:0] wptr, rptr;
  logic [ADDR:0]   count;
  logic            do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ft_async_responder.sv
// rtl/ft_async_responder.sv - FT2232H async 245-FIFO device-side responder with host byte FIFOs
module ft_async_responder
  import ft_async_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR           = 4,
  parameter int T_RD_DLY       = 3,
  parameter int T_RXF_INACTIVE = 3,
  parameter int T_TXE_INACTIVE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_rx_wr,
  input  logic [DATA_W-1:0] host_rx_data,
  output logic              host_rx_full,
  input  logic              host_tx_rd,
  output logic [DATA_W-1:0] host_tx_data,
  output logic              host_tx_valid,
  output logic              err_rd,
  output logic              err_wr,
  output logic              RXF_N,
  input  logic              RD_N,
  output logic              TXE_N,
  input  logic              WR_N,
  inout  wire  [DATA_W-1:0] DATA
);

  localparam logic [CNT_W-1:0] RD_DLY   = CNT_W'(T_RD_DLY);
  localparam logic [CNT_W-1:0] RXF_HOLD = CNT_W'(T_RXF_INACTIVE);
  localparam logic [CNT_W-1:0] TXE_HOLD = CNT_W'(T_TXE_INACTIVE);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic              rd_s1, rd_s2, wr_s1, wr_s2;
  logic [DATA_W-1:0] data_s1;
  logic              rd_fall, rd_rise, wr_fall, wr_rise;

  rx_state_t         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic              rxf_n_q, rxf_n_d;
  logic              drive_q, drive_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_rd_q, err_rd_d;
  logic              rx_pop;

  tx_state_t         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic              txe_n_q, txe_n_d;
  logic              tx_push_q, tx_push_d;
  logic [DATA_W-1:0] tx_wdata_q, tx_wdata_d;
  logic              err_wr_q, err_wr_d;

  logic [DATA_W-1:0] rx_head;
  logic              rx_full, rx_empty, tx_full, tx_empty;

  ft_sync_fifo #(.DATA(DATA_W), .ADDR(ADDR)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host_rx_wr),
    .wdata (host_rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  ft_sync_fifo #(.DATA(DATA_W), .ADDR(ADDR)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push_q),
    .wdata (tx_wdata_q),
    .pop   (host_tx_rd),
    .rdata (host_tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign host_rx_full  = rx_full;
  assign host_tx_valid = !tx_empty;
  assign err_rd        = err_rd_q;
  assign err_wr        = err_wr_q;
  assign RXF_N         = rxf_n_q;
  assign TXE_N         = txe_n_q;
  assign DATA          = drive_q ? dout_q : 'z;

  assign rd_fall = rd_s2 & ~rd_s1;
  assign rd_rise = ~rd_s2 & rd_s1;
  assign wr_fall = wr_s2 & ~wr_s1;
  assign wr_rise = ~wr_s2 & wr_s1;

  // Strobes idle high, so their sample stages reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1   <= 1'b1;
      rd_s2   <= 1'b1;
      wr_s1   <= 1'b1;
      wr_s2   <= 1'b1;
      data_s1 <= '0;
    end else begin
      rd_s1   <= RD_N;
      rd_s2   <= rd_s1;
      wr_s1   <= WR_N;
      wr_s2   <= wr_s1;
      data_s1 <= DATA;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rxf_n_d    = rxf_n_q;
    drive_d    = drive_q;
    dout_d     = dout_q;
    rx_pop     = 1'b0;
    err_rd_d   = err_rd_q | (rd_fall & rxf_n_q);
    case (rx_state_q)
      RX_IDLE: begin
        rxf_n_d = rx_empty;
        if (rd_fall && !rxf_n_q) begin
          rx_state_d = RX_WAIT;
          rx_cnt_d   = RD_DLY;
        end
      end
      RX_WAIT: begin
        if (rd_rise) begin
          rx_pop     = 1'b1;
          rxf_n_d    = 1'b1;
          rx_cnt_d   = RXF_HOLD;
          rx_state_d = RX_RECOVER;
          err_rd_d   = 1'b1;
        end else if (rx_cnt_q == CNT_ONE) begin
          drive_d    = 1'b1;
          dout_d     = rx_head;
          rx_state_d = RX_DRIVE;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_DRIVE: begin
        if (rd_rise) begin
          rx_pop     = 1'b1;
          drive_d    = 1'b0;
          rxf_n_d    = 1'b1;
          rx_cnt_d   = RXF_HOLD;
          rx_state_d = RX_RECOVER;
        end
      end
      RX_RECOVER: begin
        rxf_n_d = 1'b1;
        if (rx_cnt_q == CNT_ONE) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // The write is registered, so the FIFO takes the byte one edge after the fall is acted on.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    txe_n_d    = txe_n_q;
    tx_push_d  = 1'b0;
    tx_wdata_d = tx_wdata_q;
    err_wr_d   = err_wr_q | (wr_fall & txe_n_q) | (~wr_s1 & drive_q);
    case (tx_state_q)
      TX_IDLE: begin
        txe_n_d = tx_full;
        if (wr_fall && !txe_n_q) begin
          tx_push_d  = 1'b1;
          tx_wdata_d = data_s1;
          txe_n_d    = 1'b1;
          tx_state_d = TX_ACTIVE;
        end
      end
      TX_ACTIVE: begin
        if (wr_rise) begin
          tx_cnt_d   = TXE_HOLD;
          tx_state_d = TX_RECOVER;
        end
      end
      TX_RECOVER: begin
        if (tx_cnt_q == CNT_ONE) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rxf_n_q    <= 1'b1;
      drive_q    <= 1'b0;
      dout_q     <= '0;
      err_rd_q   <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      txe_n_q    <= 1'b1;
      tx_push_q  <= 1'b0;
      tx_wdata_q <= '0;
      err_wr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rxf_n_q    <= rxf_n_d;
      drive_q    <= drive_d;
      dout_q     <= dout_d;
      err_rd_q   <= err_rd_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      txe_n_q    <= txe_n_d;
      tx_push_q  <= tx_push_d;
      tx_wdata_q <= tx_wdata_d;
      err_wr_q   <= err_wr_d;
    end
  end

endmodule

// File: tb/tb_ft_async_responder.sv
// tb/tb_ft_async_responder.sv - directed self-checking bench for ft_async_responder
module tb_ft_async_responder;

  logic       clk = 1'b0;
  logic       rst_n, host_rx_wr, host_tx_rd, RD_N, WR_N, tb_oe;
  logic [7:0] host_rx_data, host_tx_data, tb_data, b;
  logic       host_rx_full, host_tx_valid, err_rd, err_wr, RXF_N, TXE_N;
  wire  [7:0] DATA;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  // An undriven bus reads back as 0xFF.
  assign DATA = tb_oe ? tb_data : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (DATA[g]);
  end

  ft_async_responder #(
    .DATA_W(8), .ADDR(4), .T_RD_DLY(3), .T_RXF_INACTIVE(3), .T_TXE_INACTIVE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_rx_wr(host_rx_wr), .host_rx_data(host_rx_data), .host_rx_full(host_rx_full),
    .host_tx_rd(host_tx_rd), .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .err_rd(err_rd), .err_wr(err_wr),
    .RXF_N(RXF_N), .RD_N(RD_N), .TXE_N(TXE_N), .WR_N(WR_N), .DATA(DATA)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rx_push(input logic [7:0] v);
    host_rx_data = v;
    host_rx_wr   = 1'b1;
    tick();
    host_rx_wr   = 1'b0;
  endtask

  task automatic wait_rxf_low();
    for (int i = 0; i < 20 && RXF_N !== 1'b0; i++) tick();
    chk("rxf_wait", RXF_N, 1'b0);
  endtask

  task automatic rd_byte(output logic [7:0] v);
    wait_rxf_low();
    RD_N = 1'b0;
    repeat (5) tick();
    v = DATA;
    RD_N = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wr_byte(input logic [7:0] v);
    tb_data = v;
    tb_oe   = 1'b1;
    for (int i = 0; i < 20 && TXE_N !== 1'b0; i++) tick();
    chk("txe_wait", TXE_N, 1'b0);
    repeat (2) tick();
    WR_N = 1'b0;
    repeat (3) tick();
    WR_N = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; RD_N = 1'b1; WR_N = 1'b1; tb_oe = 1'b0; tb_data = 8'h00;
    host_rx_wr = 1'b0; host_rx_data = 8'h00; host_tx_rd = 1'b0;
    repeat (3) tick();
    chk("rst_rxf", RXF_N, 1'b1);
    chk("rst_txe", TXE_N, 1'b1);
    chk("rst_data", DATA, 8'hFF);
    chk("rst_rx_full", host_rx_full, 1'b0);
    chk("rst_tx_valid", host_tx_valid, 1'b0);
    chk("rst_tx_data", host_tx_data, 8'h00);
    chk("rst_err_rd", err_rd, 1'b0);
    chk("rst_err_wr", err_wr, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_txe", TXE_N, 1'b0);
    chk("idle_rxf", RXF_N, 1'b1);

    // single RX byte
    rx_push(8'hA5);
    chk("rxf_edge_k", RXF_N, 1'b1);
    tick();
    chk("rxf_edge_k1", RXF_N, 1'b0);
    RD_N = 1'b0;
    repeat (4) tick();
    chk("rx_predrive", DATA, 8'hFF);
    tick();
    chk("rx_drive", DATA, 8'hA5);
    chk("rx_drive_rxf", RXF_N, 1'b0);
    RD_N = 1'b1;
    tick();
    chk("rx_hold_m", DATA, 8'hA5);
    tick();
    chk("rx_release", DATA, 8'hFF);
    chk("rx_release_rxf", RXF_N, 1'b1);
    repeat (6) tick();
    chk("rxf_empty", RXF_N, 1'b1);
    chk("rx_err_rd", err_rd, 1'b0);

    // single TX byte
    tb_data = 8'h3C; tb_oe = 1'b1;
    repeat (2) tick();
    WR_N = 1'b0;
    tick();
    chk("txe_pre", TXE_N, 1'b0);
    tick();
    chk("txe_hi", TXE_N, 1'b1);
    chk("txv_j", host_tx_valid, 1'b0);
    tick();
    chk("txv_j1", host_tx_valid, 1'b1);
    chk("tx_data", host_tx_data, 8'h3C);
    tick();
    WR_N = 1'b1;
    repeat (5) tick();
    chk("txe_recover", TXE_N, 1'b1);
    tick();
    chk("txe_release", TXE_N, 1'b0);
    host_tx_rd = 1'b1;
    tick();
    host_tx_rd = 1'b0;
    chk("tx_pop_valid", host_tx_valid, 1'b0);

    // TX fill, overflow strobe, drain
    for (int i = 0; i < 16; i++) wr_byte(8'h40 + 8'(i));
    repeat (6) tick();
    chk("txe_full", TXE_N, 1'b1);
    chk("tx_full_valid", host_tx_valid, 1'b1);
    chk("tx_full_head", host_tx_data, 8'h40);
    chk("tx_full_err_wr", err_wr, 1'b0);
    tb_data = 8'h99;
    WR_N = 1'b0;
    repeat (3) tick();
    WR_N = 1'b1;
    repeat (2) tick();
    chk("err_wr_full", err_wr, 1'b1);
    host_tx_rd = 1'b1;
    tick();
    host_tx_rd = 1'b0;
    chk("tx_head_after_pop", host_tx_data, 8'h41);
    repeat (2) tick();
    chk("txe_after_pop", TXE_N, 1'b0);
    for (int i = 1; i < 16; i++) begin
      chk("tx_drain", host_tx_data, 8'h40 + 8'(i));
      host_tx_rd = 1'b1;
      tick();
      host_tx_rd = 1'b0;
    end
    chk("tx_no_extra", host_tx_valid, 1'b0);
    tb_oe = 1'b0;

    // RX wrap and ordering with a dropped push when full
    for (int i = 0; i < 16; i++) rx_push(8'(i));
    chk("rx_full", host_rx_full, 1'b1);
    rx_push(8'hEE);
    rd_byte(b);
    chk("rx_order", b, 8'h00);
    chk("rx_rel2", DATA, 8'hFF);
    chk("rxf_hi_m1", RXF_N, 1'b1);
    repeat (3) tick();
    chk("rxf_recover", RXF_N, 1'b1);
    tick();
    chk("rxf_reassert", RXF_N, 1'b0);
    for (int i = 1; i < 8; i++) begin
      rd_byte(b);
      chk("rx_order", b, 8'(i));
    end
    for (int i = 16; i < 24; i++) rx_push(8'(i));
    chk("rx_full2", host_rx_full, 1'b1);
    for (int i = 8; i < 16; i++) begin
      rd_byte(b);
      chk("rx_order", b, 8'(i));
    end
    for (int i = 24; i < 32; i++) rx_push(8'(i));
    for (int i = 16; i < 32; i++) begin
      rd_byte(b);
      chk("rx_order", b, 8'(i));
    end
    chk("wrap_err_rd", err_rd, 1'b0);

    // RD_N strobe with nothing to read
    repeat (6) tick();
    RD_N = 1'b0;
    repeat (6) tick();
    chk("err_rd_empty", err_rd, 1'b1);
    chk("err_rd_data", DATA, 8'hFF);
    RD_N = 1'b1;
    repeat (2) tick();
    chk("err_rd_rxf", RXF_N, 1'b1);
    rx_push(8'h77);
    rd_byte(b);
    chk("err_rd_no_pop", b, 8'h77);

    // asynchronous reset while driving DATA
    wr_byte(8'h5A);
    tb_oe = 1'b0;
    chk("pre_rst_valid", host_tx_valid, 1'b1);
    rx_push(8'hC3);
    wait_rxf_low();
    RD_N = 1'b0;
    repeat (5) tick();
    chk("pre_rst_drive", DATA, 8'hC3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", DATA, 8'hFF);
    chk("mid_rst_rxf", RXF_N, 1'b1);
    chk("mid_rst_txe", TXE_N, 1'b1);
    chk("mid_rst_err_rd", err_rd, 1'b0);
    chk("mid_rst_err_wr", err_wr, 1'b0);
    chk("mid_rst_valid", host_tx_valid, 1'b0);
    RD_N = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
